// File: rtl/stepper_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stepper_pkg
// Purpose : Shared stepper-motor definitions: speed-code encoding (matches the
//           speed state machine), coil phase table and the 60/speed period
//           lookup in period units.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package stepper_pkg;

  // Speed codes as produced by the speed state machine; 0 and 7 both mean stop.
  typedef enum logic [2:0] {
    SPD_STOP = 3'd0,
    SPD_1    = 3'd1,
    SPD_2    = 3'd2,
    SPD_3    = 3'd3,
    SPD_4    = 3'd4,
    SPD_5    = 3'd5,
    SPD_6    = 3'd6,
    SPD_HALT = 3'd7
  } speed_e;

  // Period (in units) used when no valid speed is present.
  localparam int unsigned STOP_UNITS = 60;

  function automatic logic speed_valid(input logic [2:0] speed);
    return (speed >= 3'(SPD_1)) && (speed <= 3'(SPD_6));
  endfunction

  // 60/speed, in period units.
  function automatic logic [5:0] period_units(input logic [2:0] speed);
    logic [5:0] units;
    case (speed)
      3'(SPD_1): units = 6'd60;
      3'(SPD_2): units = 6'd30;
      3'(SPD_3): units = 6'd20;
      3'(SPD_4): units = 6'd15;
      3'(SPD_5): units = 6'd12;
      3'(SPD_6): units = 6'd10;
      default:   units = 6'(STOP_UNITS);
    endcase
    return units;
  endfunction

  // Coil pattern {A,B,C,D}; odd entries are the two-coil full-step states.
  function automatic logic [3:0] phase_coils(input logic [2:0] idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      default: pat = 4'b1001;
    endcase
    return pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/step_timer.sv
`default_nettype none
// ============================================================================
// Module  : step_timer
// Purpose : Step period counter. Counts running cycles and raises a one-cycle
//           combinational tick at the end of each period.
// Ports   : clk      - system clock
//           resetb   - asynchronous active-low reset
//           speed_i  - speed code (1..6 valid)
//           enable_i - run enable
//           tick_o   - step tick, valid in the cycle it is asserted
// Rev     : 1.0  initial release
// ============================================================================
module step_timer
  import stepper_pkg::*;
#(
  parameter int unsigned UNIT = 2
) (
  input  logic       clk,
  input  logic       resetb,
  input  logic [2:0] speed_i,
  input  logic       enable_i,
  output logic       tick_o
);

  localparam int unsigned CNT_W = $clog2(STOP_UNITS * UNIT + 1);

  logic             run_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] period_new;
  logic [CNT_W-1:0] period_cur;
  logic             run;
  logic             tick;

  assign run        = enable_i && speed_valid(speed_i);
  assign period_new = CNT_W'(period_units(speed_i)) * CNT_W'(UNIT);

  // On the first running cycle the freshly selected period already governs
  // this count, so the first tick lands a full period after run starts.
  assign period_cur = (run && !run_q) ? period_new : period_q;
  assign tick       = run && (cnt_q == (period_cur - CNT_W'(1)));

  always_comb begin
    cnt_d    = cnt_q;
    period_d = period_q;
    if (!run) begin
      cnt_d = '0;
    end else begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
      // Speed is only picked up at period boundaries or on run entry.
      if (tick || !run_q) begin
        period_d = period_new;
      end
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      period_q <= CNT_W'(STOP_UNITS * UNIT);
    end else begin
      run_q    <= run;
      cnt_q    <= cnt_d;
      period_q <= period_d;
    end
  end

  assign tick_o = tick;

endmodule
`default_nettype wire

// File: rtl/step_gen.sv
`default_nettype none
// ============================================================================
// Module  : step_gen
// Purpose : Stepper-motor step generator. Advances the coil phase index and a
//           signed position counter on each timer tick, in half- or full-step
//           mode, forward or reverse.
// Ports   : clk        - system clock
//           resetb     - asynchronous active-low reset
//           curr_speed - speed code, 1..6 valid, 0/7 stop
//           enable     - 1 run, 0 stop and hold coils
//           dir        - 0 forward, 1 reverse
//           half_step  - 1 half-step (8 states), 0 two-coil full-step
//           coils      - registered coil pattern {A,B,C,D}
//           step_pulse - one-cycle pulse per executed step
//           position   - signed step count, two's complement
// Rev     : 1.0  initial release
// ============================================================================
module step_gen
  import stepper_pkg::*;
#(
  parameter int unsigned UNIT  = 2,
  parameter int unsigned POS_W = 16
) (
  input  logic             clk,
  input  logic             resetb,
  input  logic [2:0]       curr_speed,
  input  logic             enable,
  input  logic             dir,
  input  logic             half_step,
  output logic [3:0]       coils,
  output logic             step_pulse,
  output logic [POS_W-1:0] position
);

  logic             tick;
  logic [2:0]       index_q, index_d;
  logic [2:0]       delta;
  logic [3:0]       coils_q;
  logic             pulse_q;
  logic [POS_W-1:0] pos_q, pos_d;

  step_timer #(
    .UNIT (UNIT)
  ) u_timer (
    .clk      (clk),
    .resetb   (resetb),
    .speed_i  (curr_speed),
    .enable_i (enable),
    .tick_o   (tick)
  );

  // Full-step from an even (single-coil) index moves one slot to land on an
  // odd (two-coil) entry; afterwards it hops by two. Reverse uses the
  // modulo-8 complement of the forward delta.
  always_comb begin
    if (half_step || !index_q[0]) begin
      delta = dir ? 3'd7 : 3'd1;
    end else begin
      delta = dir ? 3'd6 : 3'd2;
    end
    index_d = tick ? index_q + delta : index_q;
    if (tick) begin
      pos_d = dir ? pos_q - POS_W'(1) : pos_q + POS_W'(1);
    end else begin
      pos_d = pos_q;
    end
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      index_q <= 3'd0;
      coils_q <= 4'b1000;
      pulse_q <= 1'b0;
      pos_q   <= '0;
    end else begin
      index_q <= index_d;
      coils_q <= phase_coils(index_d);
      pulse_q <= tick;
      pos_q   <= pos_d;
    end
  end

  assign coils      = coils_q;
  assign step_pulse = pulse_q;
  assign position   = pos_q;

endmodule
`default_nettype wire
